// File: rtl/mux_pkg.sv
// Shared types and helpers for the N:1 stream multiplexer.
package mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: first request at or after ptr (round-robin) or lowest index (fixed).
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned SW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx
);

    always_comb begin
        int unsigned start;
        int unsigned k;
        logic        found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        start = mode ? 0 : 32'(ptr);
        if (start >= N) start = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (start + i) % N;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = SW'(k);
            end
        end
    end

endmodule

// File: rtl/stream_mux_nx1.sv
// Registered N:1 valid/ready stream mux with packet-atomic grants and forced-channel override.
module stream_mux_nx1
    import mux_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 32,
    parameter int unsigned ARB_MODE = 0,
    localparam int unsigned SW      = idx_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    input  logic           force_en,
    input  logic [SW-1:0]  force_sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    input  logic           out_ready,
    output logic           busy,
    output logic [SW-1:0]  grant_idx
);

    localparam int unsigned EXT = 1 << SW;

    state_t          state, state_nxt;
    logic [SW-1:0]   rr_ptr;
    logic            forced_pkt;
    logic [N-1:0]    arb_gnt;
    logic [SW-1:0]   arb_idx;
    logic [EXT-1:0]  valid_ext;
    logic [EXT-1:0]  gnt_ext;
    logic [N-1:0]    gnt_vec;
    logic [SW-1:0]   acc_idx;
    logic [W-1:0]    data_sel;
    logic            last_sel;
    logic            load_en;
    logic            accept;
    logic            forced_now;
    logic [SW-1:0]   ptr_next;

    rr_arbiter #(.N(N)) u_arb (
        .req  (in_valid),
        .ptr  (rr_ptr),
        .mode (ARB_MODE == ARB_FIXED),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    assign valid_ext = EXT'(in_valid);
    assign load_en   = ~out_valid | out_ready;

    // Locked packets ignore arbitration and force; only the held channel is eligible.
    always_comb begin
        gnt_ext = '0;
        gnt_vec = '0;
        acc_idx = grant_idx;
        if (state == LOCKED) begin
            gnt_ext[grant_idx] = 1'b1;
            gnt_vec            = gnt_ext[N-1:0];
        end else if (force_en) begin
            acc_idx = force_sel;
            if (32'(force_sel) < N && valid_ext[force_sel]) begin
                gnt_ext[force_sel] = 1'b1;
                gnt_vec            = gnt_ext[N-1:0];
            end
        end else begin
            gnt_vec = arb_gnt;
            acc_idx = arb_idx;
        end
    end

    always_comb begin
        data_sel = '0;
        last_sel = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (acc_idx == SW'(i)) begin
                data_sel = in_data[i*W +: W];
                last_sel = in_last[i];
            end
        end
    end

    assign in_ready   = load_en ? gnt_vec : '0;
    assign accept     = |(in_valid & in_ready);
    assign forced_now = (state == IDLE) ? force_en : forced_pkt;
    assign ptr_next   = (acc_idx == SW'(N - 1)) ? '0 : acc_idx + 1'b1;
    assign busy       = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = last_sel ? IDLE : LOCKED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            grant_idx  <= '0;
            rr_ptr     <= '0;
            forced_pkt <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= data_sel;
            out_last  <= last_sel;
            grant_idx <= acc_idx;
            if (state == IDLE) begin
                forced_pkt <= force_en;
            end
            if (last_sel && ARB_MODE == ARB_RR && !forced_now) begin
                rr_ptr <= ptr_next;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Directed and randomized checks of stream_mux_nx1 (round-robin N=4, fixed-priority N=6).
module tb_stream_mux_nx1;

    localparam int N0 = 4;
    localparam int N1 = 6;
    localparam int W  = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N0-1:0]   r_in_valid, r_in_last, r_in_ready;
    logic [N0*W-1:0] r_in_data;
    logic            r_force_en, r_out_valid, r_out_last, r_out_ready, r_busy;
    logic [1:0]      r_force_sel, r_grant_idx;
    logic [W-1:0]    r_out_data;

    logic [N1-1:0]   f_in_valid, f_in_last, f_in_ready;
    logic [N1*W-1:0] f_in_data;
    logic            f_force_en, f_out_valid, f_out_last, f_out_ready, f_busy;
    logic [2:0]      f_force_sel, f_grant_idx;
    logic [W-1:0]    f_out_data;

    stream_mux_nx1 #(.N(N0), .W(W), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .in_valid(r_in_valid), .in_data(r_in_data), .in_last(r_in_last), .in_ready(r_in_ready),
        .force_en(r_force_en), .force_sel(r_force_sel),
        .out_valid(r_out_valid), .out_data(r_out_data), .out_last(r_out_last), .out_ready(r_out_ready),
        .busy(r_busy), .grant_idx(r_grant_idx)
    );

    stream_mux_nx1 #(.N(N1), .W(W), .ARB_MODE(1)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .in_valid(f_in_valid), .in_data(f_in_data), .in_last(f_in_last), .in_ready(f_in_ready),
        .force_en(f_force_en), .force_sel(f_force_sel),
        .out_valid(f_out_valid), .out_data(f_out_data), .out_last(f_out_last), .out_ready(f_out_ready),
        .busy(f_busy), .grant_idx(f_grant_idx)
    );

    int tests = 0;
    int fails = 0;

    // Reference state for the random run: per-channel queues of accepted {last,data}.
    logic [32:0] q [N0][$];
    int          seq [N0];
    logic [N0-1:0] pend;
    int          cur_pkt;
    bit          stall_valid;
    logic [32:0] stall_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rr_set(input int ch, input logic v, input logic [W-1:0] d, input logic l);
        r_in_valid[ch]        = v;
        r_in_data[ch*W +: W]  = d;
        r_in_last[ch]         = l;
    endtask

    task automatic fx_set(input int ch, input logic v, input logic [W-1:0] d, input logic l);
        f_in_valid[ch]        = v;
        f_in_data[ch*W +: W]  = d;
        f_in_last[ch]         = l;
    endtask

    task automatic clear_inputs();
        r_in_valid = '0; r_in_data = '0; r_in_last = '0; r_force_en = 1'b0; r_force_sel = '0;
        r_out_ready = 1'b1;
        f_in_valid = '0; f_in_data = '0; f_in_last = '0; f_force_en = 1'b0; f_force_sel = '0;
        f_out_ready = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic rand_cycle(input bit gen);
        logic [W-1:0] d;
        logic [32:0]  exp;
        int           ch;
        for (int c = 0; c < N0; c++) begin
            if (!pend[c]) begin
                if (gen && $urandom_range(0, 1) == 1) begin
                    d = {8'(c), 24'(seq[c])};
                    rr_set(c, 1'b1, d, $urandom_range(0, 2) == 0);
                    pend[c] = 1'b1;
                end else begin
                    rr_set(c, 1'b0, '0, 1'b0);
                end
            end
        end
        r_out_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        if (stall_valid)
            check("t6_hold", {r_out_valid, r_out_last, r_out_data}, {1'b1, stall_data});
        check("t6_onehot", 64'($onehot0(r_in_ready)), 64'd1);
        if (r_out_valid && !r_out_ready)
            check("t6_stall_ready", 64'(r_in_ready), 64'd0);
        for (int c = 0; c < N0; c++) begin
            if (r_in_valid[c] && r_in_ready[c]) begin
                q[c].push_back({r_in_last[c], r_in_data[c*W +: W]});
                seq[c]++;
                pend[c] = 1'b0;
            end
        end
        if (r_out_valid && r_out_ready) begin
            ch  = int'(r_out_data[31:24]);
            exp = 33'h1_FFFF_FFFF;
            if (ch < N0 && q[ch].size() > 0) exp = q[ch].pop_front();
            check("t6_beat", {r_out_last, r_out_data}, exp);
            if (cur_pkt >= 0) check("t6_atomic", 64'(ch), 64'(cur_pkt));
            cur_pkt     = r_out_last ? -1 : ch;
            stall_valid = 1'b0;
        end else if (r_out_valid) begin
            stall_valid = 1'b1;
            stall_data  = {r_out_last, r_out_data};
        end else begin
            stall_valid = 1'b0;
        end
        tick();
    endtask

    initial begin
        int total;
        clear_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_valid", 64'(r_out_valid), 64'd0);
        check("reset_data",  64'(r_out_data),  64'd0);
        check("reset_last",  64'(r_out_last),  64'd0);
        check("reset_busy",  64'(r_busy),      64'd0);
        check("reset_grant", 64'(r_grant_idx), 64'd0);
        check("reset_fx_valid", 64'(f_out_valid), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: round-robin rotation of single-beat packets
        for (int c = 0; c < N0; c++) rr_set(c, 1'b1, 32'hA000_0000 + 32'(c), 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t1_ready", 64'(r_in_ready), 64'(1 << (k % N0)));
            tick();
            check("t1_data",  64'(r_out_data),  64'(32'hA000_0000 + 32'(k % N0)));
            check("t1_grant", 64'(r_grant_idx), 64'(k % N0));
            check("t1_valid", 64'(r_out_valid), 64'd1);
        end
        r_in_valid = '0;
        #1;
        check("t1_idle_ready", 64'(r_in_ready), 64'd0);
        tick();
        check("t1_drain", 64'(r_out_valid), 64'd0);

        // 2: three-beat packet on ch1 holds off ch2
        do_reset();
        rr_set(1, 1'b1, 32'hAAAA_0001, 1'b0);
        rr_set(2, 1'b1, 32'hDDDD_0002, 1'b1);
        #1; check("t2_ready_a", 64'(r_in_ready), 64'b0010);
        tick();
        check("t2_out_a", 64'(r_out_data), 64'hAAAA_0001);
        check("t2_busy",  64'(r_busy), 64'd1);
        check("t2_grant", 64'(r_grant_idx), 64'd1);
        rr_set(1, 1'b1, 32'hBBBB_0001, 1'b0);
        #1; check("t2_ready_b", 64'(r_in_ready), 64'b0010);
        tick();
        check("t2_out_b", 64'(r_out_data), 64'hBBBB_0001);
        rr_set(1, 1'b1, 32'hCCCC_0001, 1'b1);
        #1; check("t2_ready_c", 64'(r_in_ready), 64'b0010);
        tick();
        check("t2_out_c",  64'(r_out_data), 64'hCCCC_0001);
        check("t2_last_c", 64'(r_out_last), 64'd1);
        check("t2_unbusy", 64'(r_busy), 64'd0);
        rr_set(1, 1'b0, '0, 1'b0);
        #1; check("t2_ready_d", 64'(r_in_ready), 64'b0100);
        tick();
        check("t2_out_d",   64'(r_out_data), 64'hDDDD_0002);
        check("t2_grant_d", 64'(r_grant_idx), 64'd2);
        rr_set(2, 1'b0, '0, 1'b0);
        tick();

        // 3: downstream stall mid-packet
        do_reset();
        rr_set(0, 1'b1, 32'h5000_0000, 1'b0);
        #1; check("t3_ready_p0", 64'(r_in_ready), 64'b0001);
        tick();
        check("t3_out_p0", 64'(r_out_data), 64'h5000_0000);
        rr_set(0, 1'b1, 32'h5000_0001, 1'b0);
        r_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1; check("t3_stall_ready", 64'(r_in_ready), 64'd0);
            tick();
            check("t3_stall_data",  64'(r_out_data), 64'h5000_0000);
            check("t3_stall_valid", 64'(r_out_valid), 64'd1);
        end
        r_out_ready = 1'b1;
        #1; check("t3_ready_p1", 64'(r_in_ready), 64'b0001);
        tick();
        check("t3_out_p1", 64'(r_out_data), 64'h5000_0001);
        rr_set(0, 1'b1, 32'h5000_0002, 1'b1);
        #1; check("t3_ready_p2", 64'(r_in_ready), 64'b0001);
        tick();
        check("t3_out_p2",  64'(r_out_data), 64'h5000_0002);
        check("t3_last_p2", 64'(r_out_last), 64'd1);
        rr_set(0, 1'b0, '0, 1'b0);
        tick();
        check("t3_drain", 64'(r_out_valid), 64'd0);

        // 4: fixed priority, forced channel at packet boundary, invalid force targets
        do_reset();
        fx_set(0, 1'b1, 32'hF000_0000, 1'b1);
        fx_set(3, 1'b1, 32'hF000_0003, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1; check("t4_prio_ready", 64'(f_in_ready), 64'b000001);
            tick();
            check("t4_prio_data", 64'(f_out_data), 64'hF000_0000);
        end
        fx_set(0, 1'b1, 32'hF100_0000, 1'b0);
        #1; check("t4_pkt_ready", 64'(f_in_ready), 64'b000001);
        tick();
        check("t4_busy", 64'(f_busy), 64'd1);
        f_force_en  = 1'b1;
        f_force_sel = 3'd3;
        fx_set(0, 1'b1, 32'hF100_0001, 1'b0);
        #1; check("t4_force_locked", 64'(f_in_ready), 64'b000001);
        tick();
        check("t4_out_y1", 64'(f_out_data), 64'hF100_0001);
        fx_set(0, 1'b1, 32'hF100_0002, 1'b1);
        #1; check("t4_ready_y2", 64'(f_in_ready), 64'b000001);
        tick();
        check("t4_out_y2", 64'(f_out_data), 64'hF100_0002);
        check("t4_unbusy", 64'(f_busy), 64'd0);
        #1; check("t4_forced_ready", 64'(f_in_ready), 64'b001000);
        tick();
        check("t4_forced_data",  64'(f_out_data), 64'hF000_0003);
        check("t4_forced_grant", 64'(f_grant_idx), 64'd3);
        f_force_sel = 3'd6;
        #1; check("t4_oob_ready", 64'(f_in_ready), 64'd0);
        tick();
        check("t4_oob_drain", 64'(f_out_valid), 64'd0);
        f_force_sel = 3'd4;
        #1; check("t4_novalid_ready", 64'(f_in_ready), 64'd0);
        tick();
        check("t4_novalid_drain", 64'(f_out_valid), 64'd0);
        f_force_en = 1'b0;
        #1; check("t4_unforced_ready", 64'(f_in_ready), 64'b000001);
        tick();
        clear_inputs();

        // 5: asynchronous reset mid-packet on ch2
        do_reset();
        rr_set(2, 1'b1, 32'h2200_0000, 1'b0);
        #1; check("t5_ready", 64'(r_in_ready), 64'b0100);
        tick();
        check("t5_busy",  64'(r_busy), 64'd1);
        check("t5_grant", 64'(r_grant_idx), 64'd2);
        rr_set(2, 1'b1, 32'h2200_0001, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(r_out_valid), 64'd0);
        check("t5_rst_busy",  64'(r_busy), 64'd0);
        check("t5_rst_grant", 64'(r_grant_idx), 64'd0);
        tick();
        rst_n = 1'b1;
        rr_set(0, 1'b1, 32'h0000_00E0, 1'b1);
        #1; check("t5_next_ready", 64'(r_in_ready), 64'b0001);
        tick();
        check("t5_next_data",  64'(r_out_data), 64'h0000_00E0);
        check("t5_next_grant", 64'(r_grant_idx), 64'd0);

        // 6: randomized traffic against per-channel queues
        do_reset();
        pend        = '0;
        cur_pkt     = -1;
        stall_valid = 1'b0;
        for (int c = 0; c < N0; c++) seq[c] = 0;
        for (int k = 0; k < 10000; k++) rand_cycle(1'b1);
        for (int k = 0; k < 40; k++) rand_cycle(1'b0);
        total = 0;
        for (int c = 0; c < N0; c++) total += q[c].size();
        check("t6_drain_queues", 64'(total), 64'd0);
        check("t6_drain_valid", 64'(r_out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
